// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types, sizes and palette mirroring for the PPU line buffer
package ppu_pkg;

    typedef logic [5:0] colour_t;

    localparam int LINE_W    = 256;
    localparam int PAL_DEPTH = 32;

    // Sprite backdrop slots $10/$14/$18/$1C alias the background slots $00/$04/$08/$0C.
    function automatic logic [4:0] pal_mirror(input logic [4:0] addr);
        return (addr[4] && (addr[1:0] == 2'b00)) ? {1'b0, addr[3:0]} : addr;
    endfunction

endpackage

// File: rtl/ppu_line_buffer_if.sv
// rtl/ppu_line_buffer_if.sv - pixel, palette-CPU and display-read signals of the PPU line buffer
interface ppu_line_buffer_if;
    import ppu_pkg::*;

    logic [4:0] pixel;
    logic       pixel_valid;
    logic       line_swap;
    logic       pal_we;
    logic [4:0] pal_addr;
    colour_t    pal_wdata;
    colour_t    pal_rdata;
    logic       rd_en;
    logic [7:0] rd_x;
    colour_t    colour_out;
    logic       colour_valid;
    logic       line_full;
    logic       greyscale;

    modport master (
        output pixel, pixel_valid, line_swap, pal_we, pal_addr, pal_wdata,
        output rd_en, rd_x, greyscale,
        input  pal_rdata, colour_out, colour_valid, line_full
    );

    modport slave (
        input  pixel, pixel_valid, line_swap, pal_we, pal_addr, pal_wdata,
        input  rd_en, rd_x, greyscale,
        output pal_rdata, colour_out, colour_valid, line_full
    );

endinterface

// File: rtl/ppu_palette_ram.sv
// rtl/ppu_palette_ram.sv - 32x6 palette storage: registered pixel lookup port plus CPU write/read port
module ppu_palette_ram
    import ppu_pkg::*;
#(
    parameter int DEPTH = PAL_DEPTH
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [4:0] i_lk_addr,
    output colour_t    o_lk_data,
    input  logic       i_we,
    input  logic [4:0] i_cpu_addr,
    input  colour_t    i_wdata,
    output colour_t    o_rdata
);

    colour_t    r_mem [DEPTH];
    colour_t    r_lk_data;
    colour_t    r_rdata;
    logic [4:0] w_cpu_addr;

    assign w_cpu_addr = pal_mirror(i_cpu_addr);

    // Both reads sample the pre-write contents, so a same-edge write is seen one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[w_cpu_addr] <= i_wdata;
        r_lk_data <= r_mem[i_lk_addr];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_rdata <= '0;
        else
            r_rdata <= r_mem[w_cpu_addr];
    end

    assign o_lk_data = r_lk_data;
    assign o_rdata   = r_rdata;

endmodule

// File: rtl/ppu_line_buffer.sv
// rtl/ppu_line_buffer.sv - palette resolve and double-buffered scanline store for the PPU background
// Optional feature: PPU_LB_GREYSCALE_EN masks display colours to the grey column when greyscale is set.
module ppu_line_buffer
    import ppu_pkg::*;
#(
    parameter int LINE_W    = 256,
    parameter int PAL_DEPTH = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    ppu_line_buffer_if.slave bus
);

    logic       r_wr_bank;
    logic [8:0] r_wr_x;
    logic       r_s0_valid;
    logic       r_s0_bank;
    logic [7:0] r_s0_x;
    logic [4:0] r_s0_addr;
    logic       r_s1_valid;
    logic       r_s1_bank;
    logic [7:0] r_s1_x;
    colour_t    r_colour;
    logic       r_colour_valid;
    colour_t    r_linebuf [2][LINE_W];

    logic       w_line_full;
    logic       w_take;
    logic [4:0] w_pix_addr;
    colour_t    w_lk_data;
    colour_t    w_rd_raw;
    colour_t    w_rd_colour;

    assign w_line_full = (r_wr_x == 9'(LINE_W));
    // A swap reopens the line, so a pixel arriving with it is accepted even when full.
    assign w_take      = bus.pixel_valid && (bus.line_swap || !w_line_full);
    assign w_pix_addr  = (bus.pixel[1:0] == 2'b00) ? 5'h00 : pal_mirror(bus.pixel);
    assign w_rd_raw    = r_linebuf[~r_wr_bank][bus.rd_x];

`ifdef PPU_LB_GREYSCALE_EN
    assign w_rd_colour = bus.greyscale ? (w_rd_raw & 6'h30) : w_rd_raw;
`else
    assign w_rd_colour = w_rd_raw;
`endif

    ppu_palette_ram #(
        .DEPTH (PAL_DEPTH)
    ) u_palette (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_lk_addr  (r_s0_addr),
        .o_lk_data  (w_lk_data),
        .i_we       (bus.pal_we),
        .i_cpu_addr (bus.pal_addr),
        .i_wdata    (bus.pal_wdata),
        .o_rdata    (bus.pal_rdata)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_bank      <= 1'b0;
            r_wr_x         <= '0;
            r_s0_valid     <= 1'b0;
            r_s0_bank      <= 1'b0;
            r_s0_x         <= '0;
            r_s0_addr      <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_bank      <= 1'b0;
            r_s1_x         <= '0;
            r_colour       <= '0;
            r_colour_valid <= 1'b0;
        end else begin
            r_s0_valid <= w_take;
            if (w_take) begin
                r_s0_addr <= w_pix_addr;
                r_s0_bank <= bus.line_swap ? ~r_wr_bank : r_wr_bank;
                r_s0_x    <= bus.line_swap ? 8'd0 : r_wr_x[7:0];
            end

            if (bus.line_swap) begin
                r_wr_bank <= ~r_wr_bank;
                r_wr_x    <= {8'd0, bus.pixel_valid};
            end else if (w_take) begin
                r_wr_x <= r_wr_x + 9'd1;
            end

            // Bank and column travel with the pixel so a swap cannot redirect it.
            r_s1_valid <= r_s0_valid;
            r_s1_bank  <= r_s0_bank;
            r_s1_x     <= r_s0_x;

            r_colour_valid <= bus.rd_en;
            if (bus.rd_en)
                r_colour <= w_rd_colour;
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_s1_valid)
            r_linebuf[r_s1_bank][r_s1_x] <= w_lk_data;
    end

    assign bus.colour_out   = r_colour;
    assign bus.colour_valid = r_colour_valid;
    assign bus.line_full    = w_line_full;

endmodule

// File: tb/tb_ppu_line_buffer.sv
// tb/tb_ppu_line_buffer.sv - scoreboard bench for ppu_line_buffer
module tb_ppu_line_buffer;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [5:0] pal_model [32];
    logic [5:0] sb [$];

    ppu_line_buffer_if bus ();

    ppu_line_buffer dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] mirror(input logic [4:0] a);
        if (a == 5'h10 || a == 5'h14 || a == 5'h18 || a == 5'h1C)
            return a - 5'h10;
        return a;
    endfunction

    function automatic logic [5:0] lut(input logic [4:0] p);
        if (p[1:0] == 2'b00)
            return pal_model[0];
        return pal_model[mirror(p)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
        bus.pal_we    = 1'b1;
        bus.pal_addr  = a;
        bus.pal_wdata = d;
        tick();
        bus.pal_we    = 1'b0;
        pal_model[mirror(a)] = d;
    endtask

    task automatic push_pixel(input logic [4:0] p);
        bus.pixel_valid = 1'b1;
        bus.pixel       = p;
        tick();
        bus.pixel_valid = 1'b0;
    endtask

    task automatic swap();
        tick();
        tick();
        bus.line_swap = 1'b1;
        tick();
        bus.line_swap = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] x, input logic [5:0] exp);
        sb.push_back(exp);
        bus.rd_en = 1'b1;
        bus.rd_x  = x;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        #2;
        checks++; if (bus.colour_out !== 6'h00) begin errors++; $display("FAIL reset_colour_out: got %h want 00", bus.colour_out); end
        checks++; if (bus.colour_valid !== 1'b0) begin errors++; $display("FAIL reset_colour_valid: got %b want 0", bus.colour_valid); end
        checks++; if (bus.pal_rdata !== 6'h00) begin errors++; $display("FAIL reset_pal_rdata: got %h want 00", bus.pal_rdata); end
        checks++; if (bus.line_full !== 1'b0) begin errors++; $display("FAIL reset_line_full: got %b want 0", bus.line_full); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        exp = 6'h00;
        checks++; if (bus.colour_valid !== exp[0]) begin errors++; $display("FAIL idle_colour_valid: got %b want 0", bus.colour_valid); end
    endtask

    task automatic test_basic_lookup();
        logic [5:0] exp;
        pal_write(5'h05, 6'h16);
        push_pixel(5'h05);
        swap();
        do_read(8'd0, lut(5'h05));
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL basic_lookup: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
        tick();
        checks++; if (bus.colour_valid !== 1'b0) begin errors++; $display("FAIL valid_drops: got %b want 0", bus.colour_valid); end
    endtask

    task automatic test_transparency_mirror();
        logic [5:0] exp;
        pal_write(5'h00, 6'h0F);
        pal_write(5'h04, 6'h21);
        push_pixel(5'h04);
        push_pixel(5'h05);
        swap();
        for (int x = 0; x < 2; x++) begin
            do_read(8'(x), lut(5'(x + 4)));
            exp = sb.pop_front(); checks++;
            if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
                errors++; $display("FAIL transparency x=%0d: got %h valid=%b want %h valid=1", x, bus.colour_out, bus.colour_valid, exp);
            end
        end
        pal_write(5'h10, 6'h2A);
        checks++; if (bus.pal_rdata !== 6'h0F) begin errors++; $display("FAIL pal_rdata_old: got %h want 0f", bus.pal_rdata); end
        bus.pal_addr = 5'h00;
        tick();
        checks++; if (bus.pal_rdata !== 6'h2A) begin errors++; $display("FAIL pal_mirror_write: got %h want 2a", bus.pal_rdata); end
        bus.pal_addr = 5'h14;
        tick();
        checks++; if (bus.pal_rdata !== 6'h21) begin errors++; $display("FAIL pal_mirror_read: got %h want 21", bus.pal_rdata); end
    endtask

    task automatic test_line_full();
        logic [5:0] exp;
        for (int i = 0; i < 32; i++)
            pal_write(5'(i), 6'(i + 8));
        for (int x = 0; x < 272; x++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel       = (x < 256) ? 5'(x & 15) : 5'h13;
            tick();
            if (x == 254) begin
                checks++; if (bus.line_full !== 1'b0) begin errors++; $display("FAIL line_full_255: got %b want 0", bus.line_full); end
            end
            if (x == 255 || x == 271) begin
                checks++; if (bus.line_full !== 1'b1) begin errors++; $display("FAIL line_full_x%0d: got %b want 1", x, bus.line_full); end
            end
        end
        bus.pixel_valid = 1'b0;
        swap();
        checks++; if (bus.line_full !== 1'b0) begin errors++; $display("FAIL line_full_clear: got %b want 0", bus.line_full); end
        for (int x = 0; x < 16; x++) begin
            do_read(8'(x), lut(5'(x & 15)));
            exp = sb.pop_front(); checks++;
            if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
                errors++; $display("FAIL no_wrap x=%0d: got %h valid=%b want %h valid=1", x, bus.colour_out, bus.colour_valid, exp);
            end
        end
        do_read(8'd255, lut(5'h0F));
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL last_pixel: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
    endtask

    task automatic test_swap_collision();
        logic [5:0] exp;
        for (int x = 0; x < 256; x++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel       = (x == 255) ? 5'h0B : 5'h06;
            tick();
        end
        sb.push_back(lut(5'h03));
        bus.pixel     = 5'h0D;
        bus.line_swap = 1'b1;
        bus.rd_en     = 1'b1;
        bus.rd_x      = 8'd3;
        tick();
        bus.pixel_valid = 1'b0;
        bus.line_swap   = 1'b0;
        bus.rd_en       = 1'b0;
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL swap_read_old_bank: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
        checks++; if (bus.line_full !== 1'b0) begin errors++; $display("FAIL swap_line_full: got %b want 0", bus.line_full); end
        tick();
        tick();
        do_read(8'd255, lut(5'h0B));
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL inflight_x255: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
        do_read(8'd0, lut(5'h06));
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL old_bank_x0: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
        swap();
        do_read(8'd0, lut(5'h0D));
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL swap_pixel_x0: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
        do_read(8'd1, lut(5'h01));
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL new_bank_x1: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
    endtask

    task automatic test_reset_midline();
        logic [5:0] exp;
        for (int i = 0; i < 100; i++) begin
            bus.pixel_valid = 1'b1;
            bus.pixel       = 5'h07;
            if (i == 99) begin
                bus.rd_en    = 1'b1;
                bus.rd_x     = 8'd1;
                bus.pal_addr = 5'h01;
            end
            tick();
        end
        bus.pixel_valid = 1'b0;
        bus.rd_en       = 1'b0;
        checks++; if (bus.colour_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", bus.colour_valid); end
        reset = 1'b0;
        #2;
        checks++; if (bus.colour_out !== 6'h00) begin errors++; $display("FAIL midreset_colour_out: got %h want 00", bus.colour_out); end
        checks++; if (bus.colour_valid !== 1'b0) begin errors++; $display("FAIL midreset_colour_valid: got %b want 0", bus.colour_valid); end
        checks++; if (bus.pal_rdata !== 6'h00) begin errors++; $display("FAIL midreset_pal_rdata: got %h want 00", bus.pal_rdata); end
        checks++; if (bus.line_full !== 1'b0) begin errors++; $display("FAIL midreset_line_full: got %b want 0", bus.line_full); end
        #2;
        reset = 1'b1;
        do_read(8'd99, lut(5'h06));
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL discarded_x99: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
        do_read(8'd97, lut(5'h07));
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL written_x97: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
        push_pixel(5'h0E);
        swap();
        do_read(8'd0, lut(5'h0E));
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL post_reset_bank0_x0: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
    endtask

    task automatic test_greyscale();
        logic [5:0] exp;
        pal_write(5'h09, 6'h27);
        push_pixel(5'h09);
        swap();
        bus.greyscale = 1'b1;
`ifdef PPU_LB_GREYSCALE_EN
        do_read(8'd0, lut(5'h09) & 6'h30);
`else
        do_read(8'd0, lut(5'h09));
`endif
        exp = sb.pop_front(); checks++;
        if (bus.colour_valid !== 1'b1 || bus.colour_out !== exp) begin
            errors++; $display("FAIL greyscale: got %h valid=%b want %h valid=1", bus.colour_out, bus.colour_valid, exp);
        end
        bus.pal_addr = 5'h09;
        tick();
        checks++; if (bus.pal_rdata !== 6'h27) begin errors++; $display("FAIL greyscale_cpu: got %h want 27", bus.pal_rdata); end
        bus.greyscale = 1'b0;
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        reset           = 1'b0;
        bus.pixel       = '0;
        bus.pixel_valid = 1'b0;
        bus.line_swap   = 1'b0;
        bus.pal_we      = 1'b0;
        bus.pal_addr    = '0;
        bus.pal_wdata   = '0;
        bus.rd_en       = 1'b0;
        bus.rd_x        = '0;
        bus.greyscale   = 1'b0;
        test_reset();
        test_basic_lookup();
        test_transparency_mirror();
        test_line_full();
        test_swap_collision();
        test_reset_midline();
        test_greyscale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppu_line_buffer.md
# ppu_line_buffer

Downstream stage of the PPU background renderer. It consumes the 5-bit palette-address pixel stream and resolves each pixel through the 32-entry palette RAM into a 6-bit NES master colour. Resolved colours are written into one half of a double-buffered 256-pixel scanline buffer while the display side reads the other half. The block also owns CPU-side palette writes and reads (the $3F00–$3F1F window).

## Interface
Parameters:
- LINE_W, 256, pixels stored per scanline; pixels past this are dropped.
- PAL_DEPTH, 32, palette RAM entries.

Ports:
- clk  in  1  PPU clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- pixel  in  5  palette address {0, AT_high, AT_low, PT_high, PT_low} from the renderer.
- pixel_valid  in  1  pixel is valid this cycle.
- line_swap  in  1  one-cycle pulse at end of scanline; swaps the banks.
- pal_we  in  1  CPU palette write strobe.
- pal_addr  in  5  CPU palette address.
- pal_wdata  in  6  CPU palette write data.
- pal_rdata  out  6  CPU palette read data, registered.
- rd_en  in  1  display read request.
- rd_x  in  8  display pixel column.
- colour_out  out  6  master colour for rd_x.
- colour_valid  out  1  colour_out is valid.
- line_full  out  1  LINE_W pixels written to the current write bank.
- greyscale  in  1  greyscale request; used only when PPU_LB_GREYSCALE_EN is defined.

## Operation
- Palette mirroring: addresses 5'h10, 14, 18, 1C map to 5'h00, 04, 08, 0C. This applies to the CPU port and the pixel lookup alike.
- Transparency: if pixel[1:0]==2'b00, the lookup uses entry 5'h00 (universal background), whatever pixel[4:2] holds.
- Write pipeline has two stages:
  - S0: on pixel_valid && !line_full, register the mirrored address, write bank and wr_x; then wr_x increments.
  - S1: the palette RAM is read synchronously, and the colour is written to linebuf[bank][x].
- In-flight S1 writes always complete into the bank and x captured at S0, even if line_swap arrives in between.
- wr_x is 9 bits wide. line_full = (wr_x == LINE_W). When line_full is high, pixel_valid is ignored; there is no wrap-around. The renderer's extra prefetch tiles are discarded here.
- line_swap: toggles wr_bank, clears wr_x to 0 and clears line_full.
  - If pixel_valid arrives in the same cycle, that pixel is taken as x=0 of the new bank.
- Read side: rd_en samples linebuf[!wr_bank][rd_x].
  - If line_swap is in the same cycle, the read uses the pre-swap read bank.
- CPU palette:
  - pal_we writes the mirrored entry.
  - pal_rdata is updated every cycle from the mirrored pal_addr.
  - Upper 2 bits are stored as written; no masking.
- Palette write/lookup collision at the same entry in the same cycle: the lookup returns the old value (read-before-write).
- Reset values (async, active-low):
  - colour_out=0, colour_valid=0, pal_rdata=0, line_full=0.
  - Internal: wr_x=0, wr_bank=0, S0/S1 valid=0.
  - Palette and line-buffer contents are not reset.
- Reset asserted mid-line discards in-flight S0/S1 writes.

## Timing
- A pixel accepted at edge N is palette-read at N+1 and written into the line buffer at edge N+2.
- A pixel becomes readable after the next line_swap, provided the swap occurs at edge N+1 or later.
- Display read latency is 1 cycle: rd_en at edge N gives colour_out and colour_valid at N+1. colour_valid is low when rd_en was low.
- pal_rdata lags pal_addr by 1 cycle. A write at edge N is visible on pal_rdata at N+1 if the address is held.
- Throughput: 1 pixel/cycle sustained, with no back-pressure toward the renderer.

## Configuration
- PPU_LB_GREYSCALE_EN defined: when greyscale=1 at the read cycle, colour_out = colour & 6'h30. This applies only to the display output; CPU reads are unaffected.
- Not defined: the greyscale port exists but is ignored, and colour_out is unmasked.

## Structure
- ppu_pkg: typedef colour_t (logic [5:0]); constants LINE_W and PAL_DEPTH; function pal_mirror(input [4:0]) returning [4:0].
- Sub-module ppu_palette_ram holds the 32x6 storage:
  - one synchronous read port for the pixel lookup, registered, read-before-write;
  - one CPU port for write plus registered read.
- The line buffer stays inline as a 2x256x6 array inferred as block RAM.

## Test plan
- Palette entry 5'h05=6'h16; pixel 5'h05 at x=0; line_swap; rd_en with rd_x=0 -> colour_out=6'h16 one cycle later, colour_valid=1.
- Entry 00=6'h0F, entry 04=6'h21; pixel 5'h04 (transparent) -> 6'h0F. Write 6'h2A to 5'h10 -> pal_rdata for 5'h00 reads 6'h2A.
- Feed 272 pixels (34 tiles) -> line_full=1 after the 256th; pixels 257–272 leave the entries at x=0..15 unchanged.
- line_swap concurrent with pixel_valid and rd_en -> the pixel lands at x=0 of the new bank; the read returns old-bank data; the in-flight S1 pixel is written to the old bank at x=255.
- Reset pulse mid-line at wr_x=100 -> all outputs 0; after release, the next pixel writes x=0 of bank 0.
- With PPU_LB_GREYSCALE_EN: entry value 6'h27, greyscale=1 -> colour_out=6'h20. Without the macro -> 6'h27.
